// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multicycle control unit: opcodes, ALU codes,
// mux selects, FSM states and the bundle of control strobes.
package cpu_ctrl_pkg;

    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_ADD   = 4'h1;
    localparam logic [3:0] OP_SUB   = 4'h2;
    localparam logic [3:0] OP_AND   = 4'h3;
    localparam logic [3:0] OP_OR    = 4'h4;
    localparam logic [3:0] OP_LOAD  = 4'h5;
    localparam logic [3:0] OP_STORE = 4'h6;
    localparam logic [3:0] OP_JCOND = 4'h7;
    localparam logic [3:0] OP_JMP   = 4'h8;
    localparam logic [3:0] OP_HALT  = 4'hF;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_AND   = 3'b010;
    localparam logic [2:0] ALU_OR    = 3'b011;
    localparam logic [2:0] ALU_PASSB = 3'b100;

    localparam logic [1:0] RSEL_RS2 = 2'b00;
    localparam logic [1:0] RSEL_RS1 = 2'b01;
    localparam logic [1:0] RSEL_RD  = 2'b10;

    // A select of 1 picks the first mux input.
    localparam logic MAR_SRC_BUS1 = 1'b1;
    localparam logic MDR_SRC_MEM  = 1'b0;
    localparam logic MDR_SRC_BUS2 = 1'b1;
    localparam logic WD_SRC_BUS1  = 1'b1;

    typedef enum logic [4:0] {
        S_RST, S_F1, S_F2, S_F3, S_F4, S_DECODE,
        S_A1, S_A2, S_A3, S_L1, S_L2, S_L3,
        S_S1, S_S2, S_S3, S_J1, S_HALT
    } state_t;

    typedef struct packed {
        logic       pc_read;
        logic       pc_write;
        logic       pc_reset;
        logic       jump_en;
        logic       mar_write;
        logic       mar_src;
        logic       mdr_write;
        logic       mdr_read;
        logic       mdr_src;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       t_write;
        logic       aluout_write;
        logic       aluout_read;
        logic       aluout_reg_read;
        logic       const2_read;
        logic       rf_read;
        logic       rf_write;
        logic       rf_reset;
        logic [1:0] reg_num_src;
        logic       wd_src;
        logic [2:0] alu_ctrl;
        logic       m_write;
        logic       z_write;
        logic       o_write;
        logic       c_write;
        logic [1:0] jump_flag_sel;
        logic       halted;
    } ctrl_t;

    localparam ctrl_t CTRL_RST = '{pc_reset: 1'b1, pc_write: 1'b1, rf_reset: 1'b1, default: '0};

    function automatic logic is_wait(state_t s);
        return (s == S_F2) || (s == S_L2) || (s == S_S3);
    endfunction

endpackage

// File: rtl/control_decode.sv
// Opcode decoder: picks the first execute state and ALU function, and flags
// opcodes that are not part of the instruction set.
module control_decode
    import cpu_ctrl_pkg::*;
(
    input  logic [3:0] opcode,
    output state_t     first_state,
    output logic [2:0] alu_code,
    output logic       illegal
);

    always_comb begin
        first_state = S_F1;
        alu_code    = ALU_ADD;
        illegal     = 1'b0;
        case (opcode)
            OP_NOP:            first_state = S_F1;
            OP_ADD:            begin first_state = S_A1; alu_code = ALU_ADD; end
            OP_SUB:            begin first_state = S_A1; alu_code = ALU_SUB; end
            OP_AND:            begin first_state = S_A1; alu_code = ALU_AND; end
            OP_OR:             begin first_state = S_A1; alu_code = ALU_OR;  end
            OP_LOAD:           first_state = S_L1;
            OP_STORE:          first_state = S_S1;
            OP_JCOND, OP_JMP:  begin first_state = S_J1; alu_code = ALU_PASSB; end
            OP_HALT:           first_state = S_HALT;
            default:           illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle control FSM for the 16-bit two-bus datapath: one state per clock
// through fetch, decode, execute, memory and writeback.
module multicycle_control_unit
    import cpu_ctrl_pkg::*;
#(
    parameter int WAIT_LIMIT = 15,
    parameter int CNT_W      = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] IR_Data,
    input  logic        Mem_Ready,
    output logic        PCRead,
    output logic        PCWrite,
    output logic        PCReset,
    output logic        JumpEn,
    output logic        MARWrite,
    output logic        MARSrc,
    output logic        MDRWrite,
    output logic        MDRRead,
    output logic        MDRSrc,
    output logic        MB1_Mem_Read,
    output logic        MB1_Mem_Write,
    output logic        IRWrite,
    output logic        TWrite,
    output logic        ALUOutWrite,
    output logic        ALUOutRead,
    output logic        ALUOut_Reg_Read,
    output logic        Const_2_Read,
    output logic        RegFile_Read,
    output logic        RegFileWrite,
    output logic        RegFile_Reset,
    output logic [1:0]  RegNumberSrc,
    output logic        WD_RegFileSrc,
    output logic [2:0]  ALU_Control_Signal,
    output logic        M_write,
    output logic        Z_write,
    output logic        O_write,
    output logic        C_write,
    output logic [1:0]  Jump_Flag_Select,
    output logic        halted,
    output logic        mem_error,
    output logic        illegal_op,
    output state_t      state_dbg
);

    state_t           state, next_state;
    ctrl_t            ctrl, ctrl_nxt;
    logic             rst_hold;
    logic [CNT_W-1:0] wait_cnt;
    logic             timeout;
    state_t           dec_first;
    logic [2:0]       dec_alu;
    logic             dec_illegal;
    logic             cnt_at_limit;
    logic             unused_ir;

    assign unused_ir    = ^{IR_Data[15:10], IR_Data[7:4]};
    assign cnt_at_limit = (wait_cnt == CNT_W'(WAIT_LIMIT - 1));

    control_decode u_decode (
        .opcode      (IR_Data[3:0]),
        .first_state (dec_first),
        .alu_code    (dec_alu),
        .illegal     (dec_illegal)
    );

    // Memory handshake: a wait state holds its strobes until Mem_Ready is seen
    // high on a rising edge; that edge completes the transfer and advances.
    always_comb begin
        next_state = state;
        timeout    = 1'b0;
        case (state)
            S_RST:    next_state = rst_hold ? S_RST : S_F1;
            S_F1:     next_state = S_F2;
            S_F2: begin
                if (Mem_Ready)         next_state = S_F3;
                else if (cnt_at_limit) begin next_state = S_HALT; timeout = 1'b1; end
            end
            S_F3:     next_state = S_F4;
            S_F4:     next_state = S_DECODE;
            S_DECODE: next_state = dec_first;
            S_A1:     next_state = S_A2;
            S_A2:     next_state = S_A3;
            S_A3:     next_state = S_F1;
            S_L1:     next_state = S_L2;
            S_L2: begin
                if (Mem_Ready)         next_state = S_L3;
                else if (cnt_at_limit) begin next_state = S_HALT; timeout = 1'b1; end
            end
            S_L3:     next_state = S_F1;
            S_S1:     next_state = S_S2;
            S_S2:     next_state = S_S3;
            S_S3: begin
                if (Mem_Ready)         next_state = S_F1;
                else if (cnt_at_limit) begin next_state = S_HALT; timeout = 1'b1; end
            end
            S_J1:     next_state = S_F1;
            S_HALT:   next_state = S_HALT;
            default:  next_state = S_RST;
        endcase
    end

    // Strobes are decoded from the state about to be entered so they register
    // alongside it; IR is already stable by the time any IR-dependent state is entered.
    always_comb begin
        ctrl_nxt = '0;
        case (next_state)
            S_RST: ctrl_nxt = CTRL_RST;
            S_F1: begin
                ctrl_nxt.pc_read   = 1'b1;
                ctrl_nxt.mar_src   = MAR_SRC_BUS1;
                ctrl_nxt.mar_write = 1'b1;
                ctrl_nxt.t_write   = 1'b1;
            end
            S_F2, S_L2: begin
                ctrl_nxt.mem_read  = 1'b1;
                ctrl_nxt.mdr_src   = MDR_SRC_MEM;
                ctrl_nxt.mdr_write = 1'b1;
            end
            S_F3: begin
                ctrl_nxt.const2_read = 1'b1;
                ctrl_nxt.alu_ctrl    = ALU_ADD;
                ctrl_nxt.aluout_read = 1'b1;
                ctrl_nxt.pc_write    = 1'b1;
            end
            S_F4: begin
                ctrl_nxt.mdr_read = 1'b1;
                ctrl_nxt.ir_write = 1'b1;
            end
            S_A1: begin
                ctrl_nxt.reg_num_src = RSEL_RS1;
                ctrl_nxt.rf_read     = 1'b1;
                ctrl_nxt.t_write     = 1'b1;
            end
            S_A2: begin
                ctrl_nxt.reg_num_src  = RSEL_RS2;
                ctrl_nxt.rf_read      = 1'b1;
                ctrl_nxt.alu_ctrl     = dec_alu;
                ctrl_nxt.aluout_read  = 1'b1;
                ctrl_nxt.aluout_write = 1'b1;
                ctrl_nxt.m_write      = 1'b1;
                ctrl_nxt.z_write      = 1'b1;
                ctrl_nxt.o_write      = 1'b1;
                ctrl_nxt.c_write      = 1'b1;
            end
            S_A3: begin
                ctrl_nxt.aluout_reg_read = 1'b1;
                ctrl_nxt.wd_src          = WD_SRC_BUS1;
                ctrl_nxt.reg_num_src     = RSEL_RD;
                ctrl_nxt.rf_write        = 1'b1;
            end
            S_L1, S_S1: begin
                ctrl_nxt.reg_num_src = RSEL_RS1;
                ctrl_nxt.rf_read     = 1'b1;
                ctrl_nxt.mar_src     = MAR_SRC_BUS1;
                ctrl_nxt.mar_write   = 1'b1;
            end
            S_L3: begin
                ctrl_nxt.mdr_read    = 1'b1;
                ctrl_nxt.wd_src      = WD_SRC_BUS1;
                ctrl_nxt.reg_num_src = RSEL_RD;
                ctrl_nxt.rf_write    = 1'b1;
            end
            S_S2: begin
                ctrl_nxt.reg_num_src = RSEL_RS2;
                ctrl_nxt.rf_read     = 1'b1;
                ctrl_nxt.alu_ctrl    = ALU_PASSB;
                ctrl_nxt.aluout_read = 1'b1;
                ctrl_nxt.mdr_src     = MDR_SRC_BUS2;
                ctrl_nxt.mdr_write   = 1'b1;
            end
            S_S3: ctrl_nxt.mem_write = 1'b1;
            S_J1: begin
                ctrl_nxt.reg_num_src   = RSEL_RS1;
                ctrl_nxt.rf_read       = 1'b1;
                ctrl_nxt.alu_ctrl      = ALU_PASSB;
                ctrl_nxt.aluout_read   = 1'b1;
                ctrl_nxt.jump_flag_sel = IR_Data[9:8];
                ctrl_nxt.pc_write      = (IR_Data[3:0] == OP_JMP);
                ctrl_nxt.jump_en       = (IR_Data[3:0] != OP_JMP);
            end
            S_HALT: ctrl_nxt.halted = 1'b1;
            default: ctrl_nxt = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_RST;
            rst_hold  <= 1'b1;
            wait_cnt  <= '0;
            mem_error <= 1'b0;
            ctrl      <= CTRL_RST;
        end else begin
            state    <= next_state;
            rst_hold <= 1'b0;
            ctrl     <= ctrl_nxt;
            if (timeout) mem_error <= 1'b1;
            // Counter restarts whenever a wait state is freshly entered.
            wait_cnt <= (next_state == state && is_wait(state)) ? wait_cnt + CNT_W'(1) : '0;
        end
    end

    // IR is only loaded at the end of F4, so the illegal flag is decoded live in DECODE.
    assign illegal_op = (state == S_DECODE) && dec_illegal;

    assign state_dbg          = state;
    assign PCRead             = ctrl.pc_read;
    assign PCWrite            = ctrl.pc_write;
    assign PCReset            = ctrl.pc_reset;
    assign JumpEn             = ctrl.jump_en;
    assign MARWrite           = ctrl.mar_write;
    assign MARSrc             = ctrl.mar_src;
    assign MDRWrite           = ctrl.mdr_write;
    assign MDRRead            = ctrl.mdr_read;
    assign MDRSrc             = ctrl.mdr_src;
    assign MB1_Mem_Read       = ctrl.mem_read;
    assign MB1_Mem_Write      = ctrl.mem_write;
    assign IRWrite            = ctrl.ir_write;
    assign TWrite             = ctrl.t_write;
    assign ALUOutWrite        = ctrl.aluout_write;
    assign ALUOutRead         = ctrl.aluout_read;
    assign ALUOut_Reg_Read    = ctrl.aluout_reg_read;
    assign Const_2_Read       = ctrl.const2_read;
    assign RegFile_Read       = ctrl.rf_read;
    assign RegFileWrite       = ctrl.rf_write;
    assign RegFile_Reset      = ctrl.rf_reset;
    assign RegNumberSrc       = ctrl.reg_num_src;
    assign WD_RegFileSrc      = ctrl.wd_src;
    assign ALU_Control_Signal = ctrl.alu_ctrl;
    assign M_write            = ctrl.m_write;
    assign Z_write            = ctrl.z_write;
    assign O_write            = ctrl.o_write;
    assign C_write            = ctrl.c_write;
    assign Jump_Flag_Select   = ctrl.jump_flag_sel;
    assign halted             = ctrl.halted;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit: per-cycle strobe traces are
// collected for each instruction and compared with hand-derived patterns.
module tb_multicycle_control_unit;
    import cpu_ctrl_pkg::*;

    logic        clk, reset, Mem_Ready;
    logic [15:0] IR_Data;
    logic        PCRead, PCWrite, PCReset, JumpEn, MARWrite, MARSrc;
    logic        MDRWrite, MDRRead, MDRSrc, MB1_Mem_Read, MB1_Mem_Write;
    logic        IRWrite, TWrite, ALUOutWrite, ALUOutRead, ALUOut_Reg_Read, Const_2_Read;
    logic        RegFile_Read, RegFileWrite, RegFile_Reset, WD_RegFileSrc;
    logic [1:0]  RegNumberSrc, Jump_Flag_Select;
    logic [2:0]  ALU_Control_Signal;
    logic        M_write, Z_write, O_write, C_write;
    logic        halted, mem_error, illegal_op;
    state_t      state_dbg;

    int n_pass = 0;
    int n_total = 0;

    logic [31:0] v_rfw, v_flag_or, v_flag_and, v_mrd, v_mdrw, v_mw, v_marw, v_pcw, v_jen, v_ill;
    logic [2:0]  v_alu [32];
    logic [1:0]  v_jfs [32];
    state_t      v_state [32];

    multicycle_control_unit #(.WAIT_LIMIT(15), .CNT_W(4)) dut (
        .clk(clk), .reset(reset), .IR_Data(IR_Data), .Mem_Ready(Mem_Ready),
        .PCRead(PCRead), .PCWrite(PCWrite), .PCReset(PCReset), .JumpEn(JumpEn),
        .MARWrite(MARWrite), .MARSrc(MARSrc), .MDRWrite(MDRWrite), .MDRRead(MDRRead),
        .MDRSrc(MDRSrc), .MB1_Mem_Read(MB1_Mem_Read), .MB1_Mem_Write(MB1_Mem_Write),
        .IRWrite(IRWrite), .TWrite(TWrite), .ALUOutWrite(ALUOutWrite), .ALUOutRead(ALUOutRead),
        .ALUOut_Reg_Read(ALUOut_Reg_Read), .Const_2_Read(Const_2_Read),
        .RegFile_Read(RegFile_Read), .RegFileWrite(RegFileWrite), .RegFile_Reset(RegFile_Reset),
        .RegNumberSrc(RegNumberSrc), .WD_RegFileSrc(WD_RegFileSrc),
        .ALU_Control_Signal(ALU_Control_Signal), .M_write(M_write), .Z_write(Z_write),
        .O_write(O_write), .C_write(C_write), .Jump_Flag_Select(Jump_Flag_Select),
        .halted(halted), .mem_error(mem_error), .illegal_op(illegal_op), .state_dbg(state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $fatal(1, "FAIL watchdog: simulation exceeded time limit");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic sample(input int i);
        v_rfw[i]      = RegFileWrite;
        v_flag_or[i]  = M_write | Z_write | O_write | C_write;
        v_flag_and[i] = M_write & Z_write & O_write & C_write;
        v_mrd[i]      = MB1_Mem_Read;
        v_mdrw[i]     = MDRWrite;
        v_mw[i]       = MB1_Mem_Write;
        v_marw[i]     = MARWrite;
        v_pcw[i]      = PCWrite;
        v_jen[i]      = JumpEn;
        v_ill[i]      = illegal_op;
        v_alu[i]      = ALU_Control_Signal;
        v_jfs[i]      = Jump_Flag_Select;
        v_state[i]    = state_dbg;
    endtask

    // Records n cycles starting with the current one; Mem_Ready follows rdy per cycle.
    task automatic run(input int n, input logic [31:0] rdy);
        v_rfw = '0; v_flag_or = '0; v_flag_and = '0; v_mrd = '0; v_mdrw = '0;
        v_mw = '0; v_marw = '0; v_pcw = '0; v_jen = '0; v_ill = '0;
        for (int i = 0; i < n; i++) begin
            if (i > 0) tick();
            Mem_Ready = rdy[i];
            sample(i);
        end
    endtask

    initial begin
        reset = 1'b1; Mem_Ready = 1'b1; IR_Data = 16'h0000;

        // reset held three cycles, then one more RST cycle after release
        tick();
        chk("rst_c1_pcreset", 32'(PCReset), 32'd1);
        tick(); tick();
        chk("rst_c3_strobes", {29'd0, PCReset, PCWrite, RegFile_Reset}, 32'h7);
        chk("rst_status", {29'd0, halted, mem_error, illegal_op}, 32'h0);
        chk("rst_mem_read", 32'(MB1_Mem_Read), 32'd0);
        reset = 1'b0;
        tick();
        chk("rst_c4_pcreset", {30'd0, PCReset, PCWrite}, 32'h3);
        tick();
        chk("f1_state", 32'(state_dbg), 32'(S_F1));
        chk("f1_strobes", {27'd0, PCRead, MARSrc, MARWrite, TWrite, PCReset}, 32'h1E);

        // ADD: write-back in cycle 8, flags only in A2
        IR_Data = 16'h0401;
        run(8, 32'hFFFF_FFFF);
        chk("add_rfwrite", v_rfw, 32'h80);
        chk("add_flags_any", v_flag_or, 32'h40);
        chk("add_flags_all", v_flag_and, 32'h40);
        chk("add_alu_a2", 32'(v_alu[6]), 32'(ALU_ADD));
        chk("add_pcwrite", v_pcw, 32'h04);
        chk("add_memread", v_mrd, 32'h02);
        tick();
        chk("add_back_f1", 32'(state_dbg), 32'(S_F1));

        // SUB: ALU code follows the opcode in A2
        IR_Data = 16'h0402;
        run(8, 32'hFFFF_FFFF);
        chk("sub_alu_a2", 32'(v_alu[6]), 32'(ALU_SUB));
        chk("sub_alu_a1", 32'(v_alu[5]), 32'(ALU_ADD));
        chk("sub_rfwrite", v_rfw, 32'h80);
        tick();

        // LOAD with Mem_Ready late by three cycles in L2
        IR_Data = 16'h0005;
        run(11, 32'hFFFF_FE3F);
        chk("load_memread", v_mrd, 32'h3C2);
        chk("load_mdrwrite", v_mdrw, 32'h3C2);
        chk("load_rfwrite", v_rfw, 32'h400);
        chk("load_marwrite", v_marw, 32'h021);
        tick();
        chk("load_back_f1", 32'(state_dbg), 32'(S_F1));

        // JCOND on flag 01 with expected value 1
        IR_Data = 16'h0187;
        run(6, 32'hFFFF_FFFF);
        chk("jcond_jumpen", v_jen, 32'h20);
        chk("jcond_pcwrite", v_pcw, 32'h04);
        chk("jcond_flagsel", 32'(v_jfs[5]), 32'h1);
        chk("jcond_alu", 32'(v_alu[5]), 32'(ALU_PASSB));
        tick();

        // JMP: unconditional PC load, six cycles
        IR_Data = 16'h0008;
        run(6, 32'hFFFF_FFFF);
        chk("jmp_pcwrite", v_pcw, 32'h24);
        chk("jmp_jumpen", v_jen, 32'h0);
        tick();
        chk("jmp_back_f1", 32'(state_dbg), 32'(S_F1));

        // illegal opcode behaves as NOP with a one-cycle flag in DECODE
        IR_Data = 16'h000A;
        run(5, 32'hFFFF_FFFF);
        chk("illegal_pulse", v_ill, 32'h10);
        chk("illegal_decode_state", 32'(v_state[4]), 32'(S_DECODE));
        tick();
        chk("illegal_back_f1", {27'd0, state_dbg}, 32'(S_F1));
        chk("illegal_cleared", 32'(illegal_op), 32'd0);

        // STORE stalled in S3, then reset mid-wait
        IR_Data = 16'h0006;
        run(9, 32'hFFFF_807F);
        chk("store_memwrite", v_mw, 32'h180);
        chk("store_mdrwrite", v_mdrw, 32'h42);
        reset = 1'b1;
        tick();
        chk("store_rst_state", 32'(state_dbg), 32'(S_RST));
        chk("store_rst_memwrite", 32'(MB1_Mem_Write), 32'd0);
        chk("store_rst_pcreset", 32'(PCReset), 32'd1);
        reset = 1'b0; Mem_Ready = 1'b1;
        tick();
        chk("store_rst_extra", 32'(state_dbg), 32'(S_RST));
        tick();
        chk("store_rst_f1", 32'(state_dbg), 32'(S_F1));

        // Mem_Ready arriving in the 15th wait cycle still succeeds
        IR_Data = 16'h0000;
        run(17, 32'hFFFF_8001);
        chk("edge_memread", v_mrd, 32'h0000_FFFE);
        chk("edge_state_f3", 32'(v_state[16]), 32'(S_F3));
        chk("edge_no_error", 32'(mem_error), 32'd0);
        tick(); tick(); tick();
        chk("edge_back_f1", 32'(state_dbg), 32'(S_F1));

        // no Mem_Ready at all: 15 wait cycles, then HALT with mem_error
        run(17, 32'h0000_0001);
        chk("to_memread", v_mrd, 32'h0000_FFFE);
        chk("to_state_halt", 32'(v_state[16]), 32'(S_HALT));
        chk("to_status", {30'd0, halted, mem_error}, 32'h3);
        chk("to_strobes_off", {30'd0, MB1_Mem_Read, MDRWrite}, 32'h0);
        Mem_Ready = 1'b1;
        tick();
        chk("halt_sticky", {27'd0, state_dbg}, 32'(S_HALT));
        chk("halt_err_sticky", 32'(mem_error), 32'd1);
        reset = 1'b1;
        tick();
        chk("halt_rst_status", {30'd0, halted, mem_error}, 32'h0);
        reset = 1'b0;
        tick(); tick();
        chk("halt_rst_f1", 32'(state_dbg), 32'(S_F1));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Multicycle FSM that drives every control strobe of the 16-bit two-bus datapath (PC, MAR, MDR, IR, T, ALUOut, register bank, flags, jump logic).
- Sits directly upstream of the datapath and consumes only IR contents and a memory-ready handshake.
- Sequences fetch, decode, execute, memory and writeback one state per clock.

Parameters:
- WAIT_LIMIT, 15, max cycles spent waiting for Mem_Ready before aborting to HALT.
- CNT_W, 4, width of the wait counter; must satisfy 2^CNT_W > WAIT_LIMIT.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- IR_Data  in  16  IR contents.
- Mem_Ready  in  1  memory has completed the current read or write.
- PCRead, PCWrite, PCReset, JumpEn  out  1 each  PC strobes; JumpEn gates the flag-XNOR PC enable.
- MARWrite, MARSrc  out  1 each  MAR strobes.
- MDRWrite, MDRRead, MDRSrc  out  1 each  MDR strobes.
- MB1_Mem_Read, MB1_Mem_Write  out  1 each  memory strobes.
- IRWrite, TWrite, ALUOutWrite, ALUOutRead, ALUOut_Reg_Read, Const_2_Read  out  1 each  register and tristate strobes.
- RegFile_Read, RegFileWrite, RegFile_Reset  out  1 each  register bank strobes.
- RegNumberSrc  out  2  register select: 00=IR[6:4] (rs2), 01=IR[12:10] (rs1), 10=IR[15:13] (rd).
- WD_RegFileSrc  out  1  register write-data source: 1=Bus_1, 0=Bus_2.
- ALU_Control_Signal  out  3  ALU function.
- M_write, Z_write, O_write, C_write  out  1 each  flag write enables.
- Jump_Flag_Select  out  2  flag select for the jump mux.
- halted, mem_error, illegal_op  out  1 each  status.

Behaviour:
- Mux convention: sel=1 selects the first mux input. MARSrc=1 selects Bus_1. MDRSrc=0 selects memory data; MDRSrc=1 selects Bus_2.
- Opcode is IR[3:0]:
  - 0 NOP; 1 ADD; 2 SUB; 3 AND; 4 OR.
  - 5 LOAD: rd <- Mem[rs1].
  - 6 STORE: Mem[rs1] <- rs2.
  - 7 JCOND: jump to rs1 if flag(IR[9:8]) == IR[7].
  - 8 JMP: jump to rs1 unconditionally.
  - F HALT.
  - Any other value is a NOP and pulses illegal_op for 1 cycle in DECODE.
- Outputs are a Moore function of the state (and of IR where noted). Every strobe not listed for a state is 0.
- RST: PCReset=1, PCWrite=1, RegFile_Reset=1.
- F1: PCRead, MARSrc=1, MARWrite, TWrite.
- F2: MB1_Mem_Read, MDRSrc=0, MDRWrite. Stay in F2 until Mem_Ready.
- F3: Const_2_Read, ALU=ADD, ALUOutRead, PCWrite (PC <- PC+2).
- F4: MDRRead, IRWrite.
- DECODE: no strobes; branch on opcode. NOP and illegal opcodes go to F1.
- ALU ops, 3 states:
  - A1: RegNumberSrc=01, RegFile_Read, TWrite.
  - A2: RegNumberSrc=00, RegFile_Read, ALU=op, ALUOutRead, ALUOutWrite, M/Z/O/C_write.
  - A3: ALUOut_Reg_Read, WD_RegFileSrc=1, RegNumberSrc=10, RegFileWrite.
- LOAD:
  - L1: rs1 read, MARSrc=1, MARWrite.
  - L2: Mem_Read, MDRSrc=0, MDRWrite; wait for Mem_Ready.
  - L3: MDRRead, WD_RegFileSrc=1, RegNumberSrc=10, RegFileWrite.
- STORE:
  - S1: same as L1.
  - S2: rs2 read, ALU=PASSB, ALUOutRead, MDRSrc=1, MDRWrite.
  - S3: MB1_Mem_Write; wait for Mem_Ready.
- Jumps, 1 state J1: rs1 read, ALU=PASSB, ALUOutRead, Jump_Flag_Select=IR[9:8].
  - JMP: PCWrite=1.
  - JCOND: JumpEn=1, PCWrite=0.
  - Both then go to F1.
- Every instruction ends in F1.
- HALT state: halted=1. Only reset leaves it.
- Wait counter:
  - Cleared on entry to any wait state (F2, L2, S3); increments each cycle without Mem_Ready.
  - If the count reaches WAIT_LIMIT with no Mem_Ready: go to HALT, set mem_error (sticky until reset), deassert memory strobes.
  - Mem_Ready in the same cycle the limit is reached counts as success.
- Reset:
  - Sampled on each clk edge. reset=1 forces RST on the next edge from any state, including mid-wait; the counter clears.
  - RST lasts while reset is held plus 1 cycle, then F1.
  - Power-up / reset state: all strobes 0 except RST strobes; status outputs 0.
- Latency: ALU op 8 cycles, LOAD 8+wait, STORE 8+wait, JMP 6, NOP 5 (zero-wait memory).

Decomposition:
- Package cpu_ctrl_pkg holds:
  - opcode constants;
  - ALU codes: ADD=000, SUB=001, AND=010, OR=011, PASSB=100;
  - RegNumberSrc and mux-select encodings;
  - state enumeration.
- One sub-module, control_decode: combinational opcode -> first execute state, ALU code and illegal flag.

Test Plan:
- Reset held 3 cycles, then released -> PCReset/PCWrite high for 4 cycles, then F1 strobes; mem_error, halted and illegal_op all 0.
- IR=0x0401 (ADD), Mem_Ready tied 1 -> RegFileWrite pulses exactly in cycle 8, ALU code 000 in A2, flag writes high only in A2.
- LOAD with Mem_Ready delayed 3 cycles in L2 -> MB1_Mem_Read held 4 cycles, MDRWrite held throughout, RegFileWrite 1 cycle later.
- JCOND with IR[9:8]=01, IR[7]=1 -> J1 shows JumpEn=1, PCWrite=0, Jump_Flag_Select=01. JMP (opcode 8) -> PCWrite=1, JumpEn=0.
- Mem_Ready never asserted in F2 -> exactly 15 wait cycles, then HALT with mem_error=1 and halted=1; reset clears both.
- IR opcode 0xA -> illegal_op=1 for one DECODE cycle, then F1. Reset asserted in S3 -> RST on the next edge, MB1_Mem_Write drops to 0.
